// File: rtl/nr_divider_seq.sv
// Sequential non-restoring integer divider: one quotient bit per clock, valid/ready
// handshakes on both sides, runtime signed/unsigned mode and explicit divide-by-zero.
module nr_divider_seq #(
   parameter int N  = 32,
   parameter int CW = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         signed_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state_q;
   logic signed [N:0]   a_q;
   logic        [N-1:0] q_q;
   logic        [N-1:0] d_q;
   logic        [CW-1:0] cnt_q;
   logic                smode_q;
   logic                neg_dvd_q;
   logic                neg_dvs_q;
   logic        [N-1:0] quot_q;
   logic        [N-1:0] rem_q;
   logic                dbz_q;
   logic                out_valid_q;
   logic                in_ready_q;
   logic                busy_q;

   logic signed [N:0]   a_d;
   logic        [N-1:0] q_d;
   logic signed [N:0]   a_sh;
   logic signed [N:0]   d_ext;
   logic        [N-1:0] dvd_mag;
   logic        [N-1:0] dvs_mag;
   logic        [N-1:0] rem_mag;
   logic        [N-1:0] quot_fix;
   logic        [N-1:0] rem_fix;

   always_comb begin
      dvd_mag = (signed_mode && dividend[N-1]) ? -dividend : dividend;
      dvs_mag = (signed_mode && divisor[N-1])  ? -divisor  : divisor;
      d_ext   = $signed({1'b0, d_q});
      // Add/subtract decision follows the sign of A before the shift; the N+1 bit
      // accumulator then stays in range even for divisors up to 2^N-1.
      a_sh    = $signed({a_q[N-1:0], q_q[N-1]});
      a_d     = a_q[N] ? (a_sh + d_ext) : (a_sh - d_ext);
      q_d     = {q_q[N-2:0], ~a_d[N]};
      rem_mag = a_q[N] ? (a_q[N-1:0] + d_q) : a_q[N-1:0];
      quot_fix = (smode_q && (neg_dvd_q ^ neg_dvs_q)) ? -q_q : q_q;
      rem_fix  = (smode_q && neg_dvd_q) ? -rem_mag : rem_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  smode_q    <= signed_mode;
                  neg_dvd_q  <= signed_mode & dividend[N-1];
                  neg_dvs_q  <= signed_mode & divisor[N-1];
                  d_q        <= dvs_mag;
                  q_q        <= dvd_mag;
                  a_q        <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (divisor == '0) begin
                     quot_q      <= '1;
                     rem_q       <= dividend;
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     cnt_q   <= CW'(N);
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               a_q   <= a_d;
               q_q   <= q_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= FIX;
            end
            FIX: begin
               quot_q      <= quot_fix;
               rem_q       <= rem_fix;
               dbz_q       <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_nr_divider_seq.sv
// Randomized and directed bench for nr_divider_seq at N=32 and N=8, compared
// against an arithmetic reference model built on native integer division.
module tb_nr_divider_seq;

   logic clk;
   logic rst;

   logic        iv32, ir32, sm32, ov32, or32, dz32, busy32;
   logic [31:0] dd32, ds32, q32, r32;
   logic        iv8, ir8, sm8, ov8, or8, dz8, busy8;
   logic [7:0]  dd8, ds8, q8, r8;

   int checks = 0;
   int errors = 0;

   nr_divider_seq #(.N(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .dividend(dd32),
      .divisor(ds32), .signed_mode(sm32), .out_valid(ov32), .out_ready(or32),
      .quotient(q32), .remainder(r32), .div_by_zero(dz32), .busy(busy32));

   nr_divider_seq #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .dividend(dd8),
      .divisor(ds8), .signed_mode(sm8), .out_valid(ov8), .out_ready(or8),
      .quotient(q8), .remainder(r8), .div_by_zero(dz8), .busy(busy8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: truncating division on wide integers, masked back to w bits.
   function automatic void model(input int w, input bit sm, input logic [31:0] a_in,
                                 input logic [31:0] b_in, output logic [31:0] q,
                                 output logic [31:0] r, output bit z);
      logic [31:0] m, a, b;
      longint sa, sb;
      m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      a = a_in & m;
      b = b_in & m;
      if (b == 0) begin
         q = m; r = a; z = 1'b1;
         return;
      end
      z = 1'b0;
      if (sm) begin
         if (w == 32) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end else begin
            sa = longint'($signed(a[7:0]));
            sb = longint'($signed(b[7:0]));
         end
         q = 32'(sa / sb) & m;
         r = 32'(sa % sb) & m;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic op(input bit w8, input bit sm, input logic [31:0] a, input logic [31:0] b,
                     input int hold, input bit poke);
      logic [31:0] eq, er, gq, gr;
      bit ez;
      int lat, w;
      w = w8 ? 8 : 32;
      model(w, sm, a, b, eq, er, ez);
      @(negedge clk);
      chk("in_ready_idle", w8 ? 32'(ir8) : 32'(ir32), 32'd1);
      if (w8) begin iv8 = 1'b1; dd8 = a[7:0]; ds8 = b[7:0]; sm8 = sm; end
      else begin iv32 = 1'b1; dd32 = a; ds32 = b; sm32 = sm; end
      @(posedge clk);
      #1;
      iv8 = 1'b0; iv32 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) chk("busy", w8 ? 32'(busy8) : 32'(busy32), 32'd1);
         if (poke && lat == 2) begin
            if (w8) begin iv8 = 1'b1; dd8 = ~a[7:0]; ds8 = b[7:0] + 8'd1; sm8 = ~sm; end
            else begin iv32 = 1'b1; dd32 = ~a; ds32 = b + 32'd1; sm32 = ~sm; end
         end
         if (lat == 5) begin iv8 = 1'b0; iv32 = 1'b0; end
      end while (!(w8 ? ov8 : ov32) && lat < 200);
      iv8 = 1'b0; iv32 = 1'b0;
      chk("latency", 32'(lat), ez ? 32'd1 : 32'(w + 2));
      gq = w8 ? {24'b0, q8} : q32;
      gr = w8 ? {24'b0, r8} : r32;
      chk("quotient", gq, eq);
      chk("remainder", gr, er);
      chk("div_by_zero", w8 ? 32'(dz8) : 32'(dz32), 32'(ez));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", w8 ? 32'(ov8) : 32'(ov32), 32'd1);
         chk("hold_ready", w8 ? 32'(ir8) : 32'(ir32), 32'd0);
         chk("hold_q", w8 ? {24'b0, q8} : q32, eq);
         chk("hold_r", w8 ? {24'b0, r8} : r32, er);
      end
      if (w8) or8 = 1'b1; else or32 = 1'b1;
      @(posedge clk);
      #1;
      or8 = 1'b0; or32 = 1'b0;
      chk("valid_clear", w8 ? 32'(ov8) : 32'(ov32), 32'd0);
   endtask

   initial begin
      bit          w8r, smr;
      logic [31:0] ar, br;
      rst = 1'b1;
      iv32 = 0; sm32 = 0; or32 = 0; dd32 = 0; ds32 = 0;
      iv8 = 0; sm8 = 0; or8 = 0; dd8 = 0; ds8 = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(ir32), 32'd1);
      chk("rst_out_valid", 32'(ov32), 32'd0);
      chk("rst_busy", 32'(busy32), 32'd0);
      chk("rst_quotient", q32, 32'd0);
      chk("rst_remainder", r32, 32'd0);
      chk("rst_dbz", 32'(dz32), 32'd0);
      chk("rst_busy8", 32'(busy8), 32'd0);

      op(0, 0, 32'd304, 32'd5, 0, 0);
      op(0, 1, -32'sd7, 32'd2, 0, 0);
      op(0, 1, 32'd7, -32'sd2, 0, 0);
      op(1, 1, 32'h80, 32'hFF, 0, 0);
      op(1, 0, 32'hFF, 32'h10, 0, 0);
      op(0, 0, 32'd123, 32'd0, 0, 0);
      op(0, 1, 32'd123, 32'd0, 0, 0);
      op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      op(0, 0, 32'd1000, 32'd33, 5, 1);
      op(1, 1, 32'h85, 32'h07, 5, 1);

      // Reset during CALC must abandon the operation cleanly.
      @(negedge clk);
      iv32 = 1'b1; dd32 = 32'd5000; ds32 = 32'd3; sm32 = 1'b0;
      @(posedge clk);
      #1 iv32 = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_in_ready", 32'(ir32), 32'd1);
      chk("midrst_out_valid", 32'(ov32), 32'd0);
      chk("midrst_busy", 32'(busy32), 32'd0);
      op(0, 0, 32'd100, 32'd7, 0, 0);

      for (int i = 0; i < 40; i++) begin
         w8r = (i % 2) == 1;
         smr = 1'($urandom);
         ar  = $urandom;
         br  = $urandom;
         case ($urandom % 4)
            0: br = br % 16;
            1: br = (i % 5 == 0) ? 32'd0 : br;
            default: ;
         endcase
         op(w8r, smr, ar, br, int'($urandom % 3), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
